// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with a registered result.
// Valid/ready flow control on both sides, synchronous flush, illegal-op flag.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier; without
// it the multiply opcode is reported as illegal.

`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`define ALU_OP_SUB  4'd1
`define ALU_OP_AND  4'd2
`define ALU_OP_OR   4'd3
`define ALU_OP_XOR  4'd4
`define ALU_OP_LSL  4'd5
`define ALU_OP_LSR  4'd6
`define ALU_OP_ASR  4'd7
`define ALU_OP_MVB  4'd8
`define ALU_OP_MVT  4'd9
`define ALU_OP_SEQ  4'd10
`define ALU_OP_SLT  4'd11
`define ALU_OP_SLTE 4'd12
`endif

`ifndef ALU_OP_MUL
`define ALU_OP_MUL  4'd13
`endif

module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;

    assign accept = in_valid && in_ready;
    assign sh     = in_b[SHW-1:0];

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [CW-1:0]    cnt;

    assign is_mul   = (in_op == `ALU_OP_MUL);
    assign mul_done = (state == MUL) && (cnt == CW'(WIDTH - 1));

    // Partial-product sum including the current multiplier bit
    always_comb begin
        acc_nx = acc + (mplier[0] ? mcand : '0);
    end

    // Shift-add multiplier: one multiplier bit consumed per MUL cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept && is_mul) begin
            mcand  <= in_a;
            mplier <= in_b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= mul_done ? '0 : cnt + 1'b1;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
`endif

    // Single-cycle operation datapath; unknown opcodes yield zero with error
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (in_op)
            `ALU_OP_ADD:  alu_res = in_a + in_b;
            `ALU_OP_SUB:  alu_res = in_a - in_b;
            `ALU_OP_AND:  alu_res = in_a & in_b;
            `ALU_OP_OR:   alu_res = in_a | in_b;
            `ALU_OP_XOR:  alu_res = in_a ^ in_b;
            `ALU_OP_LSL:  alu_res = in_a << sh;
            `ALU_OP_LSR:  alu_res = in_a >> sh;
            `ALU_OP_ASR:  alu_res = $unsigned($signed(in_a) >>> sh);
            `ALU_OP_MVB:  alu_res = {in_a[WIDTH-1:WIDTH/2], in_b[WIDTH/2-1:0]};
            `ALU_OP_MVT:  alu_res = in_a | (in_b << (WIDTH / 2));
            `ALU_OP_SEQ:  alu_res = WIDTH'(in_a == in_b);
            `ALU_OP_SLT:  alu_res = WIDTH'(in_a < in_b);
            `ALU_OP_SLTE: alu_res = WIDTH'(in_a <= in_b);
            default:      alu_err = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; flush overrides everything except reset
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state_nx = is_mul ? MUL : HOLD;
                end
                MUL: begin
                    if (mul_done) state_nx = HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        if (accept) state_nx = is_mul ? MUL : HOLD;
                        else        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Handshake outputs derived from the registered state
    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = !flush && ((state == IDLE) || ((state == HOLD) && out_ready));
    end

    // Result register: loaded on single-cycle accept or multiply completion,
    // left untouched by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_res <= '0;
            out_err <= 1'b0;
        end else if (!flush) begin
            if (accept && !is_mul) begin
                out_res <= alu_res;
                out_err <= alu_err;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (mul_done) begin
                out_res <= acc_nx;
                out_err <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the CPU's combinational ALU.
- Registered result with valid/ready flow control on input and output.
- Width generalised via WIDTH; adds an iterative multiply op, an illegal-op flag and a synchronous flush.
- Sits between decode/register-read and writeback in the execute stage; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width; even, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived, do not override).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of any in-flight or held op
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- in_op  in  4  opcode, `ALU_OP_* from defines.v; `ALU_OP_MUL added at the next free code
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_res  out  WIDTH  result
- out_err  out  1  op was illegal or not compiled in; out_res=0

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE, out_valid=0, out_res=0, out_err=0, mul counter=0. in_ready=1 after release unless flush is high.
- FSM states: IDLE, MUL, HOLD.
- in_ready = !flush && (state==IDLE || (state==HOLD && out_ready)).
- Accept = in_valid && in_ready. a, b and op are captured at accept; inputs are don't-care afterwards.
- Single-cycle ops go to HOLD. out_valid is high the cycle after accept (latency 1).
- Single-cycle op semantics, all modulo 2^WIDTH:
  - ADD, SUB, AND, OR, XOR.
  - LSL: a << b[SHW-1:0]. LSR: logical right shift by b[SHW-1:0]. ASR: arithmetic right shift by b[SHW-1:0].
  - MVB: {a[WIDTH-1:WIDTH/2], b[WIDTH/2-1:0]}.
  - MVT: a | (b << WIDTH/2).
  - SEQ, SLT, SLTE: unsigned compare, result zero-extended to 0 or 1.
- Unknown opcode: HOLD with out_res=0, out_err=1, latency 1.
- MUL:
  - IDLE/HOLD -> MUL on accept.
  - Shift-add, one multiplier bit per cycle, WIDTH cycles.
  - Then -> HOLD. out_valid rises WIDTH+1 cycles after accept.
  - Result is the low WIDTH bits of the product, out_err=0.
  - in_ready=0 throughout MUL.
- HOLD:
  - out_res/out_err stable while out_valid && !out_ready.
  - out_ready && !accept -> IDLE, out_valid=0 next cycle.
  - out_ready && accept -> next op issues back-to-back (one result per cycle for single-cycle ops).
- flush (highest priority after rst): next state IDLE, out_valid=0, partial product discarded; in_ready=0 during flush. out_res keeps its last value (don't-care while out_valid=0).
- Simultaneous in_valid and flush: nothing accepted.
- rst mid-MUL or in HOLD: immediate return to reset values; the result is lost.
- out_valid must never assert without a preceding accept.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: `ALU_OP_MUL behaves as above; iterative datapath and counter are present.
- Undefined: no multiplier logic. `ALU_OP_MUL is treated as an unknown opcode (out_res=0, out_err=1, latency 1), and the MUL state is unreachable/removed.

Test Plan:
- WIDTH=32: ADD a=0x7FFFFFFF, b=1 -> next cycle out_valid=1, out_res=0x80000000, out_err=0. SUB a=0, b=1 -> 0xFFFFFFFF.
- ASR a=0x80000000, b=0x24 -> out_res=0xF8000000 (shift 4). LSR same operands -> 0x08000000. SLT a=1, b=0xFFFFFFFF -> 1.
- Back-to-back, out_ready=1: ADD, XOR, SEQ on consecutive cycles -> three results on consecutive cycles, in order. Then out_ready=0 for 3 cycles -> out_res constant, in_ready=0; out_ready=1 -> IDLE next cycle.
- With ALU_SEQ_MUL_EN: MUL a=0x12345, b=0x10 -> in_ready=0 for 32 cycles, out_valid at accept+33, out_res=0x00123450. Without the macro: out_err=1, out_res=0 at accept+1.
- Mid-MUL abort: assert flush at accept+10 -> out_valid=0, state IDLE, in_ready=1 the cycle after flush drops. Repeat with rst pulse -> outputs zero immediately, no stale result appears afterwards.
- WIDTH=16: MVT a=0x00FF, b=0x00AB -> 0xABFF. MVB a=0x12FF, b=0x3456 -> 0x1256. Illegal opcode -> out_err=1, out_res=0x0000.
